pipe_reg_elastic: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one WIDTH-bit stage payload with valid/ready flow control instead of a global stall wire.
- Provides 2-entry skid buffering, NOP substitution, synchronous flush, occupancy output and a saturating back-pressure counter.
- Sits between any two pipeline stages; a CPU pipeline is built by chaining instances.

---
 rtl/pipe_reg_elastic_if.sv | 41 ++++
 rtl/pipe_reg_elastic.sv | 124 ++++++++++++
 tb/tb_pipe_reg_elastic.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_elastic_if.sv
//------------------------------------------------------------------------------
// Module      : pipe_reg_elastic_if
// Description : Bundle of the handshake, payload and status signals of one
//               elastic pipeline register.
//               master : the environment side (drives upstream payload,
//                        flush and downstream ready)
//               slave  : the register itself
//               Signals: in_valid/in_ready/in_data/in_nop (upstream),
//                        flush, out_valid/out_ready/out_data (downstream),
//                        occupancy, stall_cnt (status).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_reg_elastic_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_nop;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_data, in_nop, flush, out_ready,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, in_nop, flush, out_ready,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_reg_elastic.sv
//------------------------------------------------------------------------------
// Module      : pipe_reg_elastic
// Description : Elastic inter-stage pipeline register with 2-entry skid
//               buffer, NOP substitution, synchronous flush, registered
//               occupancy and a saturating back-pressure (stall) counter.
//               Ports: clk, rst_n (async, active-low), bus (slave modport of
//               pipe_reg_elastic_if carrying all handshake/data/status).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_reg_elastic #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] NOP_VALUE = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pipe_reg_elastic_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_nop_value = WIDTH'(NOP_VALUE);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

  // State is the pair {main_valid, skid_valid}; 2'b01 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [WIDTH-1:0] r_main_data;
  logic             r_main_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;
  logic             r_in_ready;
  logic [1:0]       r_occupancy;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [WIDTH-1:0] w_sel;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_main_data_nxt;
  logic             w_main_valid_nxt;
  logic [WIDTH-1:0] w_skid_data_nxt;
  logic             w_skid_valid_nxt;

  assign w_sel      = bus.in_nop ? c_nop_value : bus.in_data;
  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_main_valid & bus.out_ready;

  always_comb begin
    w_main_data_nxt  = r_main_data;
    w_main_valid_nxt = r_main_valid;
    w_skid_data_nxt  = r_skid_data;
    w_skid_valid_nxt = r_skid_valid;

    if (bus.flush) begin
      // Only the valid bits clear; data registers keep their contents.
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else begin
      case ({r_main_valid, r_skid_valid})
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_valid_nxt = 1'b1;
            w_main_data_nxt  = w_sel;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_data_nxt = w_sel;
          end else if (w_in_fire) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = w_sel;
          end else if (w_out_fire) begin
            w_main_valid_nxt = 1'b0;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_data_nxt  = r_skid_data;
            w_skid_valid_nxt = 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: fall back to EMPTY.
          w_main_valid_nxt = 1'b0;
          w_skid_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data  <= '0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_occupancy  <= 2'd0;
      r_stall_cnt  <= '0;
    end else begin
      r_main_data  <= w_main_data_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      // Own flop so in_ready has no combinational path from any input.
      r_in_ready   <= ~w_skid_valid_nxt;
      r_occupancy  <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
      if (r_main_valid && !bus.out_ready && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.out_data  = r_main_data;
  assign bus.occupancy = r_occupancy;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_elastic.sv
//------------------------------------------------------------------------------
// Module      : tb_pipe_reg_elastic
// Description : Self-checking bench for pipe_reg_elastic: reset state,
//               table of directed vectors (streaming, back-pressure, NOP,
//               flush), asynchronous reset while full, stall counter
//               saturation on a CNT_W=2 instance, and randomized traffic
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_reg_elastic;

  logic clk;
  logic rst_n;

  pipe_reg_elastic_if #(.WIDTH(32), .CNT_W(16)) bus ();
  pipe_reg_elastic_if #(.WIDTH(32), .CNT_W(2))  sbus ();

  pipe_reg_elastic #(.WIDTH(32), .NOP_VALUE(32'h0000_0013), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  pipe_reg_elastic #(.WIDTH(32), .NOP_VALUE(32'h0000_0013), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        iv;
    logic        nop;
    logic        fl;
    logic        ordy;
    logic [31:0] data;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic [15:0] e_st;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO of at most two payloads plus a stall count.
  logic [31:0] mq[$];
  int          m_stall;

  task automatic model_step(input logic iv, input logic [31:0] d, input logic nop,
                            input logic fl, input logic ordy);
    logic accept;
    logic deliver;
    if (mq.size() > 0 && !ordy && m_stall < 65535) m_stall++;
    if (fl) begin
      mq.delete();
    end else begin
      accept  = iv && (mq.size() < 2);
      deliver = (mq.size() > 0) && ordy;
      if (deliver) void'(mq.pop_front());
      if (accept) mq.push_back(nop ? 32'h13 : d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid  = 0; bus.in_data  = '0; bus.in_nop  = 0; bus.flush  = 0; bus.out_ready  = 0;
    sbus.in_valid = 0; sbus.in_data = '0; sbus.in_nop = 0; sbus.flush = 0; sbus.out_ready = 0;

    //          iv nop fl ordy data          e_ov e_od          e_ir occ st
    vecs[0]  = '{1, 0, 0, 1, 32'd1,          1, 32'd1,          1, 1, 0};
    vecs[1]  = '{1, 0, 0, 1, 32'd2,          1, 32'd2,          1, 1, 0};
    vecs[2]  = '{1, 0, 0, 1, 32'd3,          1, 32'd3,          1, 1, 0};
    vecs[3]  = '{1, 0, 0, 1, 32'd4,          1, 32'd4,          1, 1, 0};
    vecs[4]  = '{0, 0, 0, 1, 32'd0,          0, 32'd0,          1, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 32'hA,          1, 32'hA,          1, 1, 0};
    vecs[6]  = '{1, 0, 0, 0, 32'hB,          1, 32'hA,          0, 2, 1};
    vecs[7]  = '{1, 0, 0, 0, 32'hC,          1, 32'hA,          0, 2, 2};
    vecs[8]  = '{0, 0, 0, 0, 32'h0,          1, 32'hA,          0, 2, 3};
    vecs[9]  = '{0, 0, 0, 1, 32'h0,          1, 32'hB,          1, 1, 3};
    vecs[10] = '{0, 0, 0, 1, 32'h0,          0, 32'h0,          1, 0, 3};
    vecs[11] = '{1, 1, 0, 0, 32'hDEADBEEF,   1, 32'h13,         1, 1, 3};
    vecs[12] = '{1, 0, 0, 0, 32'h55,         1, 32'h13,         0, 2, 4};
    vecs[13] = '{1, 0, 1, 0, 32'h77,         0, 32'h0,          1, 0, 5};
    vecs[14] = '{0, 0, 0, 1, 32'h0,          0, 32'h0,          1, 0, 5};

    // Reset state
    tick(); tick();
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("rst_out_data",  {32'd0, bus.out_data},  64'd0);
    check("rst_occupancy", {62'd0, bus.occupancy}, 64'd0);
    check("rst_stall_cnt", {48'd0, bus.stall_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Saturation on the CNT_W=2 instance
    sbus.in_valid = 1; sbus.in_data = 32'h5; sbus.out_ready = 0;
    tick();
    sbus.in_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("sat_stall_cnt", {62'd0, sbus.stall_cnt}, (k < 3) ? 64'(k) : 64'd3);
    end
    check("sat_out_data", {32'd0, sbus.out_data}, 64'h5);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      bus.in_valid  = vecs[i].iv;
      bus.in_nop    = vecs[i].nop;
      bus.flush     = vecs[i].fl;
      bus.out_ready = vecs[i].ordy;
      bus.in_data   = vecs[i].data;
      tick();
      check($sformatf("vec%0d_out_valid", i), {63'd0, bus.out_valid}, {63'd0, vecs[i].e_ov});
      if (vecs[i].e_ov)
        check($sformatf("vec%0d_out_data", i), {32'd0, bus.out_data}, {32'd0, vecs[i].e_od});
      check($sformatf("vec%0d_in_ready", i),  {63'd0, bus.in_ready},  {63'd0, vecs[i].e_ir});
      check($sformatf("vec%0d_occupancy", i), {62'd0, bus.occupancy}, {62'd0, vecs[i].e_occ});
      check($sformatf("vec%0d_stall_cnt", i), {48'd0, bus.stall_cnt}, {48'd0, vecs[i].e_st});
    end

    // Asynchronous reset while FULL
    bus.in_valid = 1; bus.in_nop = 0; bus.flush = 0; bus.out_ready = 0; bus.in_data = 32'h101;
    tick();
    bus.in_data = 32'h102;
    tick();
    bus.in_valid = 0;
    check("pre_arst_occupancy", {62'd0, bus.occupancy}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("arst_occupancy", {62'd0, bus.occupancy}, 64'd0);
    check("arst_stall_cnt", {48'd0, bus.stall_cnt}, 64'd0);
    check("arst_out_data",  {32'd0, bus.out_data},  64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the reference model
    mq.delete();
    m_stall = 0;
    for (int c = 0; c < 2000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.in_nop    = ($urandom_range(0, 7) == 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      model_step(bus.in_valid, bus.in_data, bus.in_nop, bus.flush, bus.out_ready);
      tick();
      check("rnd_out_valid", {63'd0, bus.out_valid}, (mq.size() > 0) ? 64'd1 : 64'd0);
      if (mq.size() > 0)
        check("rnd_out_data", {32'd0, bus.out_data}, {32'd0, mq[0]});
      check("rnd_in_ready",  {63'd0, bus.in_ready},  (mq.size() < 2) ? 64'd1 : 64'd0);
      check("rnd_occupancy", {62'd0, bus.occupancy}, 64'(mq.size()));
      check("rnd_stall_cnt", {48'd0, bus.stall_cnt}, 64'(m_stall));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
